alu_simd_pipe: RTL and testbench

// - Pipelined, handshaked successor of the single-width ternary SIMD adder: S = W + X + Y + CIN per segment.
// - The LANES*LANE_W datapath splits at run time into 1, 2 or LANES independent segments.
// - Adds an accumulate mode (W replaced by the segment's previous result) and saturating per-lane carry counters.
// - Sits after the multiplier partial-product stage, feeding the post-adder / output register in the MAC models.

---
 rtl/alu_simd_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_simd_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_simd_pipe.sv
// Two-stage pipelined ternary SIMD adder: S = W + X + Y + CIN per run-time segment,
// with per-segment accumulate and per-lane saturating carry-out counters.
module alu_simd_pipe #(
  parameter int LANE_W = 12,
  parameter int LANES  = 4,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                simd_mode,
  input  logic                      acc_en,
  input  logic [LANES*LANE_W-1:0]   w,
  input  logic [LANES*LANE_W-1:0]   x,
  input  logic [LANES*LANE_W-1:0]   y,
  input  logic [2*LANES-1:0]        cin,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANES*LANE_W-1:0]   s,
  output logic [2*LANES-1:0]        cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      clr_cnt,
  output logic [LANES*CNT_W-1:0]    carry_cnt
);

  localparam int N    = LANES * LANE_W;
  localparam int HALF = LANES / 2;

  // Handshake: a beat moves across an interface on a rising edge where valid && ready;
  // valid never depends on ready, and a held beat keeps its data stable until taken.
  logic             advance;
  logic             acc_hazard;
  logic             in_fire;
  logic             out_fire;
  logic [N-1:0]     w_eff;

  logic             s1_valid;
  logic [N-1:0]     s1_ps;
  logic [N-1:0]     s1_pc;
  logic [2*LANES-1:0] s1_cin;
  logic [1:0]       s1_mode;

  logic [N-1:0]     acc_q;
  logic [N-1:0]     sum_n;
  logic [2*LANES-1:0] cout_n;
  logic [LANES*CNT_W-1:0] cnt_n;

  assign advance    = !out_valid || out_ready;
  assign acc_hazard = s1_valid && acc_en;
  assign in_ready   = advance && !acc_hazard && rst_n;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  // An acc_en beat is only accepted with S1 empty, so acc_q here already equals
  // the value it will hold when this beat reaches S2.
  assign w_eff = acc_en ? acc_q : w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ps    <= '0;
      s1_pc    <= '0;
      s1_cin   <= '0;
      s1_mode  <= 2'd0;
    end else if (advance) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_ps   <= w_eff ^ x ^ y;
        s1_pc   <= (w_eff & x) | (w_eff & y) | (x & y);
        s1_cin  <= cin;
        s1_mode <= simd_mode;
      end
    end
  end

  // Lane-by-lane carry-propagate add; the 2-bit lane carry is restarted from cin
  // at a segment's bottom lane and reported as cout at its top lane.
  always_comb begin
    logic [1:0]        c;
    logic [LANE_W+1:0] lane_t;
    logic              is_bot;
    logic              is_top;
    sum_n  = '0;
    cout_n = '0;
    c      = 2'b00;
    lane_t = '0;
    is_bot = 1'b0;
    is_top = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      case (s1_mode)
        2'd0: begin
          is_bot = (i == 0);
          is_top = (i == LANES - 1);
        end
        2'd1: begin
          is_bot = ((i % HALF) == 0);
          is_top = ((i % HALF) == HALF - 1);
        end
        default: begin
          is_bot = 1'b1;
          is_top = 1'b1;
        end
      endcase
      if (is_bot) c = s1_cin[2*i +: 2];
      lane_t = {2'b00, s1_ps[i*LANE_W +: LANE_W]}
             + {1'b0, s1_pc[i*LANE_W +: LANE_W], 1'b0}
             + {{LANE_W{1'b0}}, c};
      sum_n[i*LANE_W +: LANE_W] = lane_t[LANE_W-1:0];
      if (is_top) cout_n[2*i +: 2] = lane_t[LANE_W +: 2];
      else        c = lane_t[LANE_W +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= '0;
      acc_q     <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s     <= sum_n;
        cout  <= cout_n;
        acc_q <= sum_n;
      end
    end
  end

  always_comb begin
    logic [CNT_W:0] t;
    cnt_n = carry_cnt;
    t     = '0;
    for (int i = 0; i < LANES; i++) begin
      t = {1'b0, carry_cnt[i*CNT_W +: CNT_W]} + {{(CNT_W-1){1'b0}}, cout[2*i +: 2]};
      cnt_n[i*CNT_W +: CNT_W] = t[CNT_W] ? {CNT_W{1'b1}} : t[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        carry_cnt <= '0;
    else if (clr_cnt)  carry_cnt <= '0;
    else if (out_fire) carry_cnt <= cnt_n;
  end

endmodule

// File: tb/tb_alu_simd_pipe.sv
// Bench for alu_simd_pipe: scoreboard of whole-segment sums plus directed scenario tasks.
module tb_alu_simd_pipe;
  localparam int LANE_W = 12;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;
  localparam int N      = LANES * LANE_W;
  localparam int CW     = 2 * LANES;
  localparam int EW     = N + CW;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             simd_mode;
  logic                   acc_en;
  logic [N-1:0]           w, x, y;
  logic [CW-1:0]          cin;
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           s;
  logic [CW-1:0]          cout;
  logic                   out_valid;
  logic                   out_ready;
  logic                   clr_cnt;
  logic [LANES*CNT_W-1:0] carry_cnt;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0]          exp_q[$];
  logic [N-1:0]           model_acc;
  logic [LANES*CNT_W-1:0] model_cnt;
  logic [EW-1:0]          mon_e;
  logic [EW-1:0]          mon_n;
  bit                     mon_have;
  bit                     rand_ready = 1'b0;

  alu_simd_pipe #(.LANE_W(LANE_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .simd_mode(simd_mode), .acc_en(acc_en),
    .w(w), .x(x), .y(y), .cin(cin), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .carry_cnt(carry_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Reference: each segment summed as one wide unsigned number.
  function automatic logic [EW-1:0] model_sum(input logic [1:0] mode, input logic [N-1:0] a,
                                               input logic [N-1:0] b, input logic [N-1:0] c,
                                               input logic [CW-1:0] ci);
    int seg_w, nseg, lo, bot, top;
    logic [63:0] mask, tot;
    logic [N-1:0] sv;
    logic [CW-1:0] cv;
    seg_w = (mode == 2'd0) ? N : (mode == 2'd1) ? N / 2 : LANE_W;
    nseg  = N / seg_w;
    mask  = (64'd1 << seg_w) - 64'd1;
    sv = '0;
    cv = '0;
    for (int k = 0; k < nseg; k++) begin
      lo  = k * seg_w;
      bot = lo / LANE_W;
      top = (lo + seg_w) / LANE_W - 1;
      tot = ((64'(a) >> lo) & mask) + ((64'(b) >> lo) & mask) + ((64'(c) >> lo) & mask)
          + (64'(ci >> (2 * bot)) & 64'h3);
      sv = sv | N'((tot & mask) << lo);
      cv = cv | CW'(((tot >> seg_w) & 64'h3) << (2 * top));
    end
    return {cv, sv};
  endfunction

  // scoreboard: push on input handshake, pop and compare on output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_acc = '0;
      model_cnt = '0;
    end else begin
      mon_have = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got s=%h cout=%h, required no output", s, cout);
        end else begin
          mon_e = exp_q.pop_front();
          mon_have = 1'b1;
          if ({cout, s} !== mon_e) begin
            failures++;
            $display("FAIL sb_result: got cout=%h s=%h, required cout=%h s=%h",
                     cout, s, mon_e[EW-1:N], mon_e[N-1:0]);
          end
        end
      end
      if (clr_cnt) model_cnt = '0;
      else if (mon_have) begin
        for (int i = 0; i < LANES; i++) begin
          int v;
          v = int'(model_cnt[i*CNT_W +: CNT_W]) + int'(mon_e[N + 2*i +: 2]);
          if (v > (1 << CNT_W) - 1) v = (1 << CNT_W) - 1;
          model_cnt[i*CNT_W +: CNT_W] = CNT_W'(v);
        end
      end
      if (in_valid && in_ready) begin
        mon_n = model_sum(simd_mode, acc_en ? model_acc : w, x, y, cin);
        model_acc = mon_n[N-1:0];
        exp_q.push_back(mon_n);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    acc_en   = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    idle_inputs();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [1:0] mode, input logic acc, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic [N-1:0] c, input logic [CW-1:0] ci);
    bit done;
    done = 1'b0;
    simd_mode = mode; acc_en = acc; w = a; x = b; y = c; cin = ci; in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle_inputs();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    out_ready = 1'b1; simd_mode = 2'd0; w = '0; x = '0; y = '0; cin = '0;
    apply_reset(0);
    rst_n = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (s !== '0) begin failures++; $display("FAIL reset_s: got %h required 0", s); end
    if (cout !== '0) begin failures++; $display("FAIL reset_cout: got %h required 0", cout); end
    if (carry_cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %h required 0", carry_cnt); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lanes_full_carry();
    send_beat(2'd2, 1'b0, {4{12'hFFF}}, {4{12'hFFF}}, {4{12'hFFF}}, 8'hFF);
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_latency_early: out_valid=%b required 0", out_valid); end
    tick();
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL t1_latency: out_valid=%b required 1", out_valid); end
    if (s !== '0) begin failures++; $display("FAIL t1_s: got %h required 0", s); end
    if (cout !== 8'hFF) begin failures++; $display("FAIL t1_cout: got %h required ff", cout); end
    drain();
    checks++;
    if (carry_cnt !== 16'h3333) begin failures++; $display("FAIL t1_cnt: got %h required 3333", carry_cnt); end
  endtask

  task automatic test_segment_modes();
    send_beat(2'd0, 1'b0, 48'hFFFF_FFFF_FFFF, 48'h1, 48'h0, 8'h00);
    idle_inputs();
    tick();
    checks += 2;
    if (s !== '0) begin failures++; $display("FAIL t2_mode0_s: got %h required 0", s); end
    if (cout !== 8'h40) begin failures++; $display("FAIL t2_mode0_cout: got %h required 40", cout); end
    drain();
    send_beat(2'd2, 1'b0, 48'hFFFF_FFFF_FFFF, 48'h1, 48'h0, 8'h00);
    send_beat(2'd1, 1'b0, 48'hFFFF_FFFF_FFFF, 48'h1, 48'h0, 8'h00);
    send_beat(2'd3, 1'b0, 48'h800_FFF_7FF_001, 48'h800_001_801_FFF, 48'h0, 8'hB6);
    send_beat(2'd1, 1'b0, 48'h7FFFFF_FFFFFF, 48'h800000_000001, 48'h1, 8'h0B);
    drain();
  endtask

  task automatic test_accumulate();
    logic [N-1:0] junk;
    apply_reset(1);
    out_ready = 1'b1;
    junk = N'({$urandom, $urandom});
    send_beat(2'd1, 1'b1, junk, 48'h000000_000100, 48'h0, 8'h00);
    for (int b = 0; b < 2; b++) begin
      simd_mode = 2'd1; acc_en = 1'b1; w = ~junk; x = 48'h000000_000100; y = '0; cin = '0;
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL t3_bubble: in_ready=%b required 0", in_ready); end
      send_beat(2'd1, 1'b1, ~junk, 48'h000000_000100, 48'h0, 8'h00);
    end
    drain();
    checks++;
    if (s !== 48'h000000_000300) begin failures++; $display("FAIL t3_final: got %h required 000000000300", s); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send_beat(2'd2, 1'b0, N'({$urandom, $urandom}), N'({$urandom, $urandom}), 48'h5, 8'h12);
    send_beat(2'd0, 1'b0, N'({$urandom, $urandom}), N'({$urandom, $urandom}), 48'h7, 8'h03);
    simd_mode = 2'd1; acc_en = 1'b0; w = 48'h123_456_789_ABC; x = 48'hFED_CBA_987_654; y = 48'h1; cin = 8'h21;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL t4_in_ready: got %b required 0", in_ready); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL t4_out_valid: got %b required 1", out_valid); end
    end
    checks++;
    if (exp_q.size() != 2) begin failures++; $display("FAIL t4_held: %0d beats held, required 2", exp_q.size()); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(2'd1, 1'b0, 48'h123_456_789_ABC, 48'hFED_CBA_987_654, 48'h1, 8'h21);
    drain();
  endtask

  task automatic test_saturation();
    apply_reset(1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++)
      send_beat(2'd2, 1'b0, 48'hFFF_000_000_000, 48'hFFF_000_000_000, 48'hFFF_000_000_000, 8'hC0);
    drain();
    checks++;
    if (carry_cnt !== 16'hF000) begin failures++; $display("FAIL t5_sat: got %h required f000", carry_cnt); end
    out_ready = 1'b0;
    send_beat(2'd2, 1'b0, 48'hFFF_000_000_000, 48'hFFF_000_000_000, 48'hFFF_000_000_000, 8'hC0);
    idle_inputs();
    tick();
    clr_cnt = 1'b1;
    out_ready = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks += 2;
    if (carry_cnt !== '0) begin failures++; $display("FAIL t5_clr: got %h required 0", carry_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL t5_clr_xfer: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    send_beat(2'd2, 1'b0, {4{12'hFFF}}, {4{12'hFFF}}, {4{12'hFFF}}, 8'hFF);
    drain();
    out_ready = 1'b0;
    send_beat(2'd2, 1'b0, {4{12'hABC}}, {4{12'h123}}, '0, 8'h55);
    send_beat(2'd0, 1'b0, 48'h1, 48'h2, 48'h3, 8'h01);
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_out_valid: got %b required 0", out_valid); end
    if (s !== '0) begin failures++; $display("FAIL t6_s: got %h required 0", s); end
    if (carry_cnt !== '0) begin failures++; $display("FAIL t6_cnt: got %h required 0", carry_cnt); end
    out_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_stale: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_beat(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                N'({$urandom, $urandom}), N'({$urandom, $urandom}),
                N'({$urandom, $urandom}), 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        idle_inputs();
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    drain();
    checks++;
    if (carry_cnt !== model_cnt) begin
      failures++;
      $display("FAIL rand_cnt: got %h required %h", carry_cnt, model_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_lanes_full_carry();
    test_segment_modes();
    test_accumulate();
    test_stall();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
